// File: rtl/audio_send_stereo_fifo.sv
// audio_send_stereo_fifo: I2S stereo transmitter fed by a FIFO of {left,right} pairs, with underrun tracking and mute
module audio_send_stereo_fifo #(
  parameter int WL = 32,
  parameter int FIFO_AW = 2
) (
  input  logic             aud_bclk,
  input  logic             sys_rst,
  input  logic             aud_lrc,
  output logic             aud_dacdat,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WL-1:0]    s_left,
  input  logic [WL-1:0]    s_right,
  input  logic             mute,
  output logic [FIFO_AW:0] fifo_level,
  output logic             frame_done,
  output logic             underrun,
  output logic [15:0]      underrun_cnt
);
  localparam int DEPTH = 2 ** FIFO_AW;
  logic [2*WL-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic aud_lrc_d0, lrc_edge, left_start, push, pop, empty;
  logic [5:0] tx_cnt;
  logic [WL-1:0] left_t, right_t, word;
  assign lrc_edge = aud_lrc ^ aud_lrc_d0;
  assign left_start = lrc_edge & ~aud_lrc;
  assign empty = fifo_level == '0;
  assign s_ready = fifo_level != (FIFO_AW+1)'(DEPTH);
  assign push = s_valid & s_ready;
  assign pop = left_start & ~empty;
  assign word = (aud_lrc_d0 ? right_t : left_t) << tx_cnt;
  always_ff @(posedge aud_bclk)
    if (push) mem[wr_ptr] <= {s_left, s_right};
  always_ff @(posedge aud_bclk or negedge sys_rst)
    if (!sys_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      aud_lrc_d0   <= 1'b0;
      tx_cnt       <= '0;
      left_t       <= '0;
      right_t      <= '0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      aud_lrc_d0 <= aud_lrc;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      tx_cnt <= lrc_edge ? '0 : tx_cnt + 6'(tx_cnt != 6'd63);
      // high exactly while tx_cnt == WL in the right slot
      frame_done <= ~lrc_edge & aud_lrc_d0 & (tx_cnt == 6'(WL - 1));
      underrun <= left_start & empty;
      if (left_start & empty & ~&underrun_cnt) underrun_cnt <= underrun_cnt + 1'b1;
      if (left_start) {left_t, right_t} <= (empty | mute) ? '0 : mem[rd_ptr];
    end
  always_ff @(negedge aud_bclk or negedge sys_rst)
    if (!sys_rst) aud_dacdat <= 1'b0;
    else aud_dacdat <= (tx_cnt < 6'(WL)) & word[WL-1];
endmodule

// File: tb/tb_audio_send_stereo_fifo.sv
// tb_audio_send_stereo_fifo: directed checks of the I2S stereo FIFO transmitter at WL=32 and WL=16
module tb_audio_send_stereo_fifo;
  logic aud_bclk = 0, sys_rst = 0;
  logic lrc = 1, dat, valid = 0, ready, mute = 0, fd, ur;
  logic [31:0] left = 0, right = 0;
  logic [2:0] level;
  logic [15:0] ucnt;
  logic lrc16 = 1, dat16, valid16 = 0, ready16, mute16 = 0, fd16, ur16;
  logic [15:0] left16 = 0, right16 = 0, ucnt16;
  logic [2:0] level16;
  logic [127:0] cap;
  logic [63:0] cap16;
  int fd_n = 0, ur_n = 0, fd16_n = 0;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] l, r;
    logic        m;
    logic [31:0] el, er;
  } vec_t;
  vec_t v[4];

  audio_send_stereo_fifo #(.WL(32), .FIFO_AW(2)) u32 (
    .aud_bclk(aud_bclk), .sys_rst(sys_rst), .aud_lrc(lrc), .aud_dacdat(dat),
    .s_valid(valid), .s_ready(ready), .s_left(left), .s_right(right), .mute(mute),
    .fifo_level(level), .frame_done(fd), .underrun(ur), .underrun_cnt(ucnt)
  );
  audio_send_stereo_fifo #(.WL(16), .FIFO_AW(2)) u16 (
    .aud_bclk(aud_bclk), .sys_rst(sys_rst), .aud_lrc(lrc16), .aud_dacdat(dat16),
    .s_valid(valid16), .s_ready(ready16), .s_left(left16), .s_right(right16), .mute(mute16),
    .fifo_level(level16), .frame_done(fd16), .underrun(ur16), .underrun_cnt(ucnt16)
  );

  always #5 aud_bclk = ~aud_bclk;
  // the codec side: data captured on rising BCLK, pulses counted on falling BCLK
  always @(posedge aud_bclk) begin
    cap <= {cap[126:0], dat};
    cap16 <= {cap16[62:0], dat16};
  end
  always @(negedge aud_bclk) begin
    fd_n += fd;
    ur_n += ur;
    fd16_n += fd16;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic frame(input int n, input bit w16);
    @(negedge aud_bclk);
    if (w16) lrc16 = 0; else lrc = 0;
    repeat (n) @(negedge aud_bclk);
    if (w16) lrc16 = 1; else lrc = 1;
    repeat (n) @(negedge aud_bclk);
    @(posedge aud_bclk);
    #1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    @(negedge aud_bclk);
    valid = 1; left = l; right = r;
    @(negedge aud_bclk);
    valid = 0;
  endtask

  task automatic push16(input logic [15:0] l, input logic [15:0] r);
    @(negedge aud_bclk);
    valid16 = 1; left16 = l; right16 = r;
    @(negedge aud_bclk);
    valid16 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, u;
    v[0] = '{32'h1111_2222, 32'h3333_4444, 1'b0, 32'h1111_2222, 32'h3333_4444};
    v[1] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567};
    v[2] = '{32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h0, 32'h0};
    v[3] = '{32'h7FFF_FFFE, 32'h0000_0080, 1'b0, 32'h7FFF_FFFE, 32'h0000_0080};

    repeat (3) @(negedge aud_bclk);
    chk("reset dacdat", dat, 0);
    chk("reset level", level, 0);
    chk("reset frame_done", fd, 0);
    chk("reset underrun", ur, 0);
    chk("reset underrun_cnt", ucnt, 0);
    chk("reset s_ready", ready, 1);
    sys_rst = 1;

    // single pair, 64-BCLK slots
    push(32'hA5A5_0001, 32'h8000_00FF);
    chk("t1 level after push", level, 1);
    b = fd_n; u = ur_n;
    frame(64, 0);
    chk("t1 serial frame", cap, {32'hA5A5_0001, 32'h0, 32'h8000_00FF, 32'h0});
    chk("t1 frame_done pulses", fd_n - b, 1);
    chk("t1 no underrun", ur_n - u, 0);
    chk("t1 level after frame", level, 0);

    // fill, overflow attempt, then replay in order
    for (int i = 0; i < 4; i++) push(v[i].l, v[i].r);
    chk("t2 level full", level, 4);
    chk("t2 s_ready full", ready, 0);
    push(32'hCAFE_F00D, 32'hBAAD_F00D);
    chk("t2 level after dropped push", level, 4);
    for (int i = 0; i < 4; i++) begin
      mute = v[i].m;
      b = fd_n;
      frame(64, 0);
      chk("t2 frame data", cap, {v[i].el, 32'h0, v[i].er, 32'h0});
      chk("t2 level", level, 3 - i);
      chk("t2 frame_done pulses", fd_n - b, 1);
    end
    mute = 0;

    // empty FIFO underruns
    u = ur_n;
    for (int i = 0; i < 3; i++) begin
      frame(64, 0);
      chk("t3 silence", cap, 0);
    end
    chk("t3 underrun pulses", ur_n - u, 3);
    chk("t3 underrun_cnt", ucnt, 3);
    chk("t3 level", level, 0);

    // push on the same edge as left_start with an empty FIFO
    @(negedge aud_bclk);
    lrc = 0; valid = 1; left = 32'h0F0F_F0F0; right = 32'h1357_9BDF;
    @(negedge aud_bclk);
    valid = 0;
    chk("t4 underrun pulse", ur, 1);
    chk("t4 level kept", level, 1);
    repeat (63) @(negedge aud_bclk);
    lrc = 1;
    repeat (64) @(negedge aud_bclk);
    @(posedge aud_bclk);
    #1;
    chk("t4 silence", cap, 0);
    chk("t4 underrun_cnt", ucnt, 4);
    frame(64, 0);
    chk("t4 deferred pair", cap, {32'h0F0F_F0F0, 32'h0, 32'h1357_9BDF, 32'h0});
    chk("t4 level drained", level, 0);

    // WL=16 in 32-BCLK slots, then a muted frame
    push16(16'h1234, 16'hFFFF);
    b = fd16_n;
    frame(32, 1);
    chk("t5 wl16 frame", cap16, {16'h1234, 16'h0, 16'hFFFF, 16'h0});
    chk("t5 wl16 frame_done", fd16_n - b, 1);
    chk("t5 wl16 level", level16, 0);
    push16(16'h1234, 16'hFFFF);
    chk("t5 wl16 level before mute", level16, 1);
    mute16 = 1;
    frame(32, 1);
    mute16 = 0;
    chk("t5 muted frame", cap16, 0);
    chk("t5 muted level", level16, 0);
    chk("t5 wl16 underrun_cnt", ucnt16, 0);

    // reset in the middle of a left word
    for (int i = 0; i < 3; i++) push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t6 level queued", level, 3);
    @(negedge aud_bclk);
    lrc = 0;
    repeat (10) @(negedge aud_bclk);
    chk("t6 dacdat before reset", dat, 1);
    #2 sys_rst = 0;
    #1;
    chk("t6 dacdat in reset", dat, 0);
    chk("t6 level in reset", level, 0);
    chk("t6 s_ready in reset", ready, 1);
    chk("t6 underrun_cnt in reset", ucnt, 0);
    @(negedge aud_bclk);
    sys_rst = 1;
    repeat (53) @(negedge aud_bclk);
    lrc = 1;
    repeat (64) @(negedge aud_bclk);
    u = ur_n;
    frame(64, 0);
    chk("t6 silence after reset", cap, 0);
    chk("t6 underrun after reset", ur_n - u, 1);
    chk("t6 underrun_cnt after reset", ucnt, 1);
    chk("t6 level after reset", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
